// File: rtl/fpmul_pkg.sv
// Shared types for the FP32 multiplier front-end arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: FP32 word width, FSM state encodings/enum, latched operand pair,
// and a modulo increment helper for the round-robin pointer.
package fpmul_pkg;

    localparam int FP32_W = 32;

    // Raw encodings kept as plain constants so older code that compares
    // against bit patterns still lines up with the enum below.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND_A = 2'd1;
    localparam logic [1:0] S_SEND_B = 2'd2;
    localparam logic [1:0] S_WAIT_Z = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_SEND_A = S_SEND_A,
        ST_SEND_B = S_SEND_B,
        ST_WAIT_Z = S_WAIT_Z
    } fsm_state_t;

    // Operand pair captured at grant time; the requester may change its
    // inputs afterwards without affecting the operation in flight.
    typedef struct packed {
        logic [FP32_W-1:0] a;
        logic [FP32_W-1:0] b;
    } operand_t;

    // (idx + 1) mod n for idx already in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is actually taken.
//
// Ports: req     - request vector, one bit per requester
//        ptr     - highest-priority index this cycle (must be < NUM_REQ)
//        gnt_vld - at least one request is set
//        gnt_idx - index of the selected requester (0 when gnt_vld is low)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx
);

    int j;

    // Walk offsets from farthest to nearest so the candidate closest to ptr
    // is the last one written and therefore wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one strobe/ack FP32 multiplier among NUM_REQ requesters, round-robin.
// Latency: grant -> operand A strobe next cycle; result pulse 1 cycle after the product handshake.
// Backpressure: one op in flight; grants only in IDLE; strobes held until the unit acks.
//
// Ports: clk/rst          - clock, synchronous active-high reset (also resets the unit)
//        req_valid/a/b    - per-requester operand pair offer
//        req_ready        - one-hot single-cycle accept pulse
//        rsp_valid/id/z   - single-cycle result pulse with owner index and product
//        busy             - an operation is in flight
//        input_a*/input_b*/output_z* - strobe/ack link to the multiplier unit
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][FP32_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][FP32_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [FP32_W-1:0]                rsp_z,
    output logic                             busy,
    output logic [FP32_W-1:0]                input_a,
    output logic                             input_a_stb,
    input  logic                             input_a_ack,
    output logic [FP32_W-1:0]                input_b,
    output logic                             input_b_stb,
    input  logic                             input_b_ack,
    input  logic [FP32_W-1:0]                output_z,
    input  logic                             output_z_stb,
    output logic                             output_z_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);

    fsm_state_t        state;
    fsm_state_t        state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gnt_id;
    operand_t          op_q;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic              grant;
    logic              a_hs;
    logic              b_hs;
    logic              z_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    // Handshake outputs are qualified with !rst so nothing is offered or
    // accepted during a reset cycle, whatever state the FSM was left in.
    assign grant        = !rst && (state == ST_IDLE) && pick_vld;
    assign input_a_stb  = !rst && (state == ST_SEND_A);
    assign input_b_stb  = !rst && (state == ST_SEND_B);
    assign output_z_ack = !rst && (state == ST_WAIT_Z);
    assign busy         = !rst && (state != ST_IDLE);

    assign a_hs = input_a_stb  && input_a_ack;
    assign b_hs = input_b_stb  && input_b_ack;
    assign z_hs = output_z_ack && output_z_stb;

    // Operands come from the grant-time capture, so they stay stable across
    // any number of stall cycles regardless of what the requester does.
    assign input_a = op_q.a;
    assign input_b = op_q.b;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant) state_nxt = ST_SEND_A;
            ST_SEND_A: if (a_hs)  state_nxt = ST_SEND_B;
            ST_SEND_B: if (b_hs)  state_nxt = ST_WAIT_Z;
            ST_WAIT_Z: if (z_hs)  state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= z_hs;
            if (grant) begin
                // Pointer moves just past the winner so it drops to lowest
                // priority for the next round.
                ptr       <= IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
                gnt_id    <= pick_idx;
                op_q.a    <= req_a[pick_idx];
                op_q.b    <= req_b[pick_idx];
            end
            if (z_hs) begin
                rsp_z  <= output_z;
                rsp_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter with a strobe/ack multiplier stand-in.
// Latency: n/a.
// Backpressure: stand-in delays acks/product strobe by a programmable stall.
module tb_fpmul_arbiter;

    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] z;
    } rsp_t;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0][31:0]    req_a;
    logic [NUM_REQ-1:0][31:0]    req_b;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        rsp_valid;
    logic [1:0]                  rsp_id;
    logic [31:0]                 rsp_z;
    logic                        busy;
    logic [31:0]                 input_a;
    logic                        input_a_stb;
    logic                        input_a_ack;
    logic [31:0]                 input_b;
    logic                        input_b_stb;
    logic                        input_b_ack;
    logic [31:0]                 output_z;
    logic                        output_z_stb;
    logic                        output_z_ack;

    fpmul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_z        (rsp_z),
        .busy         (busy),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Scoreboard: expected grant order and expected results.
    int   exp_gnt[$];
    rsp_t exp_rsp[$];

    // Requester model state.
    int          cnt  [NUM_REQ];
    logic [31:0] va   [NUM_REQ];
    logic [31:0] vb   [NUM_REQ];
    logic [31:0] pa   [NUM_REQ];
    logic [31:0] pb   [NUM_REQ];
    logic [31:0] pz   [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_seen;

    // Multiplier stand-in state.
    int          stall;
    int          a_wait, b_wait, z_wait;
    logic [31:0] cap_a, cap_b;
    logic        spurious_z;

    // Monitor history.
    logic        prev_gnt;
    logic        prev_a_stb, prev_b_stb;
    logic [31:0] prev_a, prev_b;
    int          a_cycles, b_cycles, z_cycles;
    int          overlap_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Ordered lookup: swapped operands fall to the poison default.
    function automatic logic [31:0] fp_product(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F9D70A4_4091EB85: return 32'h40B37B4A;
            64'h44F6AF68_4610099B: return 32'h4B8ACBEC;
            64'h473FF936_C6DDE29C: return 32'hCEA66413;
            64'h3F800000_40000000: return 32'h40000000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt[i] > 0) begin
                req_valid[i] = 1'b1;
                req_a[i]     = va[i];
                req_b[i]     = vb[i];
            end else begin
                req_valid[i] = 1'b0;
                req_a[i]     = 32'hBAD0_0000 | 32'(i);
                req_b[i]     = 32'hBAD1_0000 | 32'(i);
            end
        end
    endtask

    task automatic monitor();
        rsp_t e;
        if (rst) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
        end
        if (req_ready != '0) begin
            check("gnt_onehot", 32'($countones(req_ready)), 32'd1);
            check("gnt_has_valid", 32'(req_ready & ~req_valid), 32'd0);
            if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(onehot_idx(req_ready)), 32'hFFFF_FFFF);
            else check("gnt_id", 32'(onehot_idx(req_ready)), 32'(exp_gnt.pop_front()));
        end
        if (prev_gnt) begin
            check("lat_send_a", 32'(input_a_stb), 32'd1);
        end
        if (rsp_valid) begin
            if (req_ready != '0) overlap_seen++;
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_z", rsp_z, e.z);
            end
        end
        if (input_a_stb && prev_a_stb) check("a_stable", input_a, prev_a);
        if (input_b_stb && prev_b_stb) check("b_stable", input_b, prev_b);
        if (input_a_stb || input_b_stb || output_z_ack) begin
            check("one_phase", 32'(int'(input_a_stb) + int'(input_b_stb) + int'(output_z_ack)), 32'd1);
        end
        a_cycles += int'(input_a_stb);
        b_cycles += int'(input_b_stb);
        z_cycles += int'(output_z_ack);
        gnt_seen   = rst ? '0 : (req_ready & req_valid);
        prev_gnt   = !rst && (req_ready != '0);
        prev_a_stb = input_a_stb;
        prev_b_stb = input_b_stb;
        prev_a     = input_a;
        prev_b     = input_b;
    endtask

    task automatic bus_model();
        if (rst) begin
            input_a_ack  = 1'b0;
            input_b_ack  = 1'b0;
            output_z_stb = 1'b0;
            output_z     = 32'h0;
            a_wait = 0; b_wait = 0; z_wait = 0;
        end else begin
            if (input_a_stb) begin
                if (a_wait >= stall) begin input_a_ack = 1'b1; cap_a = input_a; end
                else begin a_wait++; input_a_ack = 1'b0; end
            end else begin
                a_wait = 0; input_a_ack = 1'b0;
            end
            if (input_b_stb) begin
                if (b_wait >= stall) begin input_b_ack = 1'b1; cap_b = input_b; end
                else begin b_wait++; input_b_ack = 1'b0; end
            end else begin
                b_wait = 0; input_b_ack = 1'b0;
            end
            if (output_z_ack) begin
                if (z_wait >= stall) begin
                    output_z_stb = 1'b1;
                    output_z     = fp_product(cap_a, cap_b);
                end else begin
                    z_wait++;
                    output_z_stb = 1'b0;
                end
            end else begin
                z_wait       = 0;
                output_z_stb = spurious_z;
                output_z     = 32'h1234_5678;
            end
        end
    endtask

    // One clock: observe at the falling edge, react just after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_seen[i] && cnt[i] > 0) cnt[i]--;
        end
        drive_reqs();
        bus_model();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_gnt.size() != 0 || exp_rsp.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            exp_gnt.delete();
            exp_rsp.delete();
        end
    endtask

    task automatic load(input int id, input int ops);
        cnt[id] = ops;
        va[id]  = pa[id];
        vb[id]  = pb[id];
    endtask

    initial begin
        rsp_t r;
        int   n;
        n_checks = 0; n_errors = 0;
        pa[0] = 32'h3F9D70A4; pb[0] = 32'h4091EB85; pz[0] = 32'h40B37B4A;
        pa[1] = 32'h44F6AF68; pb[1] = 32'h4610099B; pz[1] = 32'h4B8ACBEC;
        pa[2] = 32'h473FF936; pb[2] = 32'hC6DDE29C; pz[2] = 32'hCEA66413;
        pa[3] = 32'h3F800000; pb[3] = 32'h40000000; pz[3] = 32'h40000000;
        for (int i = 0; i < NUM_REQ; i++) begin cnt[i] = 0; va[i] = '0; vb[i] = '0; end
        stall = 0; spurious_z = 1'b0; cap_a = '0; cap_b = '0;
        a_wait = 0; b_wait = 0; z_wait = 0;
        prev_gnt = 1'b0; prev_a_stb = 1'b0; prev_b_stb = 1'b0; prev_a = '0; prev_b = '0;
        a_cycles = 0; b_cycles = 0; z_cycles = 0; overlap_seen = 0; gnt_seen = '0;
        input_a_ack = 1'b0; input_b_ack = 1'b0; output_z_stb = 1'b0; output_z = '0;

        // Reset held two cycles with requester 0 already asking.
        rst = 1'b1;
        load(0, 1);
        drive_reqs();
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_z",     rsp_z,          32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_a_stb",     32'(input_a_stb),  32'd0);
        check("rst_b_stb",     32'(input_b_stb),  32'd0);
        check("rst_z_ack",     32'(output_z_ack), 32'd0);
        check("rst_input_a",   input_a,        32'd0);
        check("rst_input_b",   input_b,        32'd0);

        // Single operation from requester 0.
        exp_gnt.push_back(0);
        r.id = 2'd0; r.z = pz[0]; exp_rsp.push_back(r);
        rst = 1'b0;
        wait_done("single", 50);

        // Product strobe outside WAIT_Z must be ignored.
        spurious_z = 1'b1;
        repeat (3) tick();
        spurious_z = 1'b0;
        tick();
        check("spur_busy", 32'(busy), 32'd0);

        // Stalled handshakes: three wait cycles on each phase.
        stall = 3; a_cycles = 0; b_cycles = 0; z_cycles = 0;
        load(1, 1);
        exp_gnt.push_back(1);
        r.id = 2'd1; r.z = pz[1]; exp_rsp.push_back(r);
        wait_done("stall", 80);
        check("stall_a_len", 32'(a_cycles), 32'd4);
        check("stall_b_len", 32'(b_cycles), 32'd4);
        check("stall_z_len", 32'(z_cycles), 32'd4);

        // Reset while waiting for the product: the op is dropped silently.
        stall = 5;
        load(3, 1);
        exp_gnt.push_back(3);
        n = 0;
        while (!output_z_ack && n < 60) begin tick(); n++; end
        if (n >= 60) check("abort_reach_wait_z", 32'd0, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  32'(busy),         32'd0);
        check("abort_z_ack", 32'(output_z_ack), 32'd0);
        stall = 0;
        repeat (8) tick();
        load(2, 1);
        exp_gnt.push_back(2);
        r.id = 2'd2; r.z = pz[2]; exp_rsp.push_back(r);
        wait_done("after_abort", 50);

        // All four at once right after reset: pointer restarts at 0.
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            load(i, 1);
            exp_gnt.push_back(i);
            r.id = 2'(i); r.z = pz[i]; exp_rsp.push_back(r);
        end
        rst = 1'b0;
        wait_done("all_four", 120);

        // Fairness between two continuously asserted requesters.
        load(1, 3);
        load(3, 3);
        for (int k = 0; k < 3; k++) begin
            exp_gnt.push_back(1);
            r.id = 2'd1; r.z = pz[1]; exp_rsp.push_back(r);
            exp_gnt.push_back(3);
            r.id = 2'd3; r.z = pz[3]; exp_rsp.push_back(r);
        end
        wait_done("fair", 150);
        check("rsp_gnt_overlap", 32'(overlap_seen != 0), 32'd1);
        tick();
        check("end_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
